// File: rtl/sy_pkg.sv
// Shared types and width helpers for the sy cache replacement blocks.
package sy_pkg;

   typedef enum logic {PLRU_INIT, PLRU_IDLE} cache_plru_state_e;

   function automatic int way_wth(input int way_num);
      return (way_num > 1) ? $clog2(way_num) : 1;
   endfunction

   // one heap-ordered bit per internal tree node; a single-way set keeps a dummy bit
   function automatic int tree_wth(input int way_num);
      return (way_num > 1) ? way_num - 1 : 1;
   endfunction

endpackage

// File: rtl/sy_cache_plru_pick.sv
// Combinational victim pick: invalid-unlocked first, else lock-aware tree walk.
module sy_cache_plru_pick
   import sy_pkg::*;
#(
   parameter int WAY_NUM = 8,
   parameter int WAY_WTH = way_wth(WAY_NUM),
   parameter int TREE_W  = tree_wth(WAY_NUM)
) (
   input  logic [TREE_W-1:0]  tree_i,
   input  logic [WAY_NUM-1:0] valid_i,
   input  logic [WAY_NUM-1:0] lock_i,
   output logic [WAY_WTH-1:0] way_o,
   output logic               all_lock_o
);

   localparam int LVL = $clog2(WAY_NUM);

   // full[n] is set when every way under heap node n is locked; leaves sit at WAY_NUM+w
   function automatic logic [WAY_WTH-1:0] tree_walk(input logic [TREE_W-1:0]  tree,
                                                    input logic [WAY_NUM-1:0] lock);
      logic [2*WAY_NUM-1:0] full;
      logic [2*WAY_NUM-1:0] fsh;
      logic [TREE_W-1:0]    tsh;
      int                   n;
      full = {lock, {WAY_NUM{1'b0}}};
      for (int k = WAY_NUM - 1; k >= 1; k--) full[k] = full[2*k] & full[2*k+1];
      n = 1;
      for (int l = 0; l < LVL; l++) begin
         tsh = tree >> (n - 1);
         n   = 2 * n + (tsh[0] ? 1 : 0);
         fsh = full >> n;
         if (fsh[0]) n = n ^ 1;
      end
      return WAY_WTH'(n - WAY_NUM);
   endfunction

   logic [WAY_NUM-1:0] free_inv;
   logic [WAY_WTH-1:0] inv_way;
   logic [WAY_WTH-1:0] walk_way;

   always_comb begin
      way_o      = '0;
      free_inv   = ~valid_i & ~lock_i;
      inv_way    = '0;
      for (int w = WAY_NUM - 1; w >= 0; w--) begin
         if (free_inv[w]) inv_way = WAY_WTH'(w);
      end
      walk_way   = tree_walk(tree_i, lock_i);
      all_lock_o = &lock_i;
      if (all_lock_o)     way_o = '0;
      else if (|free_inv) way_o = inv_way;
      else                way_o = walk_way;
   end

endmodule

// File: rtl/sy_cache_plru.sv
// Tree pseudo-LRU replacement engine: per-set tree bits, multi-port touch, 1-cycle victim query.
module sy_cache_plru
   import sy_pkg::*;
#(
   parameter int SET_NUM   = 256,
   parameter int WAY_NUM   = 8,
   parameter int UPD_PORTS = 2,
   parameter int SET_WTH   = $clog2(SET_NUM),
   parameter int WAY_WTH   = way_wth(WAY_NUM)
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                flush_i,
   output logic                                ready_o,
   input  logic [UPD_PORTS-1:0]                upd_vld_i,
   input  logic [UPD_PORTS-1:0][SET_WTH-1:0]   upd_set_i,
   input  logic [UPD_PORTS-1:0][WAY_WTH-1:0]   upd_way_i,
   input  logic                                lkp_vld_i,
   input  logic [SET_WTH-1:0]                  lkp_set_i,
   input  logic [WAY_NUM-1:0]                  lkp_valid_i,
   input  logic [WAY_NUM-1:0]                  lkp_lock_i,
   output logic                                vic_vld_o,
   output logic [WAY_WTH-1:0]                  vic_way_o,
   output logic                                vic_all_lock_o
);

   localparam int LVL    = $clog2(WAY_NUM);
   localparam int TREE_W = tree_wth(WAY_NUM);

   cache_plru_state_e  state_q, state_d;
   logic [SET_WTH-1:0] cnt_q, cnt_d;
   logic [TREE_W-1:0]  tree_rd;
   logic [WAY_WTH-1:0] pick_way;
   logic               pick_all_lock;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= PLRU_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // sweep clears one set per cycle; a flush at any point restarts it from set 0
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         PLRU_INIT: begin
            if (flush_i) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + SET_WTH'(1);
               if (cnt_q == SET_WTH'(SET_NUM - 1)) state_d = PLRU_IDLE;
            end
         end
         PLRU_IDLE: begin
            if (flush_i) begin
               state_d = PLRU_INIT;
               cnt_d   = '0;
            end
         end
         default: state_d = PLRU_INIT;
      endcase
   end

   assign ready_o = (state_q == PLRU_IDLE);

   if (WAY_NUM > 1) begin : g_tree
      logic [SET_NUM-1:0][TREE_W-1:0]          tree_q;
      logic [UPD_PORTS-1:0][LVL-1:0][WAY_WTH-1:0] upd_node;
      logic [UPD_PORTS-1:0][LVL-1:0]              upd_dir;

      // level-l node on the path to way w is heap node 2^l + (w >> (LVL-l)), stored at index-1
      for (genvar gp = 0; gp < UPD_PORTS; gp++) begin : g_port
         for (genvar gl = 0; gl < LVL; gl++) begin : g_lvl
            assign upd_node[gp][gl] = WAY_WTH'((2 ** gl) - 1) + (upd_way_i[gp] >> (LVL - gl));
            assign upd_dir[gp][gl]  = ~upd_way_i[gp][LVL-1-gl];
         end
      end

      // later ports overwrite earlier ones on shared nodes
      always_ff @(posedge clk_i) begin
         if (state_q == PLRU_INIT) begin
            tree_q[cnt_q] <= '0;
         end else begin
            for (int p = 0; p < UPD_PORTS; p++) begin
               if (upd_vld_i[p]) begin
                  for (int l = 0; l < LVL; l++) begin
                     tree_q[upd_set_i[p]][upd_node[p][l]] <= upd_dir[p][l];
                  end
               end
            end
         end
      end

      assign tree_rd = tree_q[lkp_set_i];
   end else begin : g_no_tree
      assign tree_rd = '0;
   end

   sy_cache_plru_pick #(
      .WAY_NUM (WAY_NUM),
      .WAY_WTH (WAY_WTH),
      .TREE_W  (TREE_W)
   ) u_pick (
      .tree_i     (tree_rd),
      .valid_i    (lkp_valid_i),
      .lock_i     (lkp_lock_i),
      .way_o      (pick_way),
      .all_lock_o (pick_all_lock)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vic_vld_o      <= 1'b0;
         vic_way_o      <= '0;
         vic_all_lock_o <= 1'b0;
      end else begin
         vic_vld_o <= ready_o & lkp_vld_i;
         if (ready_o && lkp_vld_i) begin
            vic_way_o      <= pick_way;
            vic_all_lock_o <= pick_all_lock;
         end
      end
   end

endmodule

// File: tb/tb_sy_cache_plru.sv
// Self-checking bench for sy_cache_plru: directed plan steps, then random traffic vs a range-based model.
module tb_sy_cache_plru;

   localparam int SET_NUM   = 256;
   localparam int WAY_NUM   = 8;
   localparam int UPD_PORTS = 2;
   localparam int SET_WTH   = 8;
   localparam int WAY_WTH   = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                              rst, flush, ready;
   logic [UPD_PORTS-1:0]              upd_vld;
   logic [UPD_PORTS-1:0][SET_WTH-1:0] upd_set;
   logic [UPD_PORTS-1:0][WAY_WTH-1:0] upd_way;
   logic                              lkp_vld;
   logic [SET_WTH-1:0]                lkp_set;
   logic [WAY_NUM-1:0]                lkp_valid, lkp_lock;
   logic                              vic_vld, vic_all_lock;
   logic [WAY_WTH-1:0]                vic_way;

   sy_cache_plru #(
      .SET_NUM(SET_NUM), .WAY_NUM(WAY_NUM), .UPD_PORTS(UPD_PORTS)
   ) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .ready_o(ready),
      .upd_vld_i(upd_vld), .upd_set_i(upd_set), .upd_way_i(upd_way),
      .lkp_vld_i(lkp_vld), .lkp_set_i(lkp_set), .lkp_valid_i(lkp_valid), .lkp_lock_i(lkp_lock),
      .vic_vld_o(vic_vld), .vic_way_o(vic_way), .vic_all_lock_o(vic_all_lock)
   );

   // model: ptr_up[s][n] says heap node n currently names its upper half as the victim side
   bit ptr_up [SET_NUM][WAY_NUM];
   int rem;
   int e_way;
   bit e_vld, e_all;
   int n_tests, n_fail;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit range_locked(input logic [WAY_NUM-1:0] lk, input int lo, input int hi);
      for (int w = lo; w < hi; w++) if (!lk[w]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_clear();
      for (int s = 0; s < SET_NUM; s++)
         for (int n = 0; n < WAY_NUM; n++) ptr_up[s][n] = 1'b0;
   endtask

   task automatic model_touch(input int s, input int w);
      int lo, hi, n, mid;
      lo = 0; hi = WAY_NUM; n = 1;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (w < mid) begin ptr_up[s][n] = 1'b1; hi = mid; n = 2 * n; end
         else         begin ptr_up[s][n] = 1'b0; lo = mid; n = 2 * n + 1; end
      end
   endtask

   task automatic model_victim(input int s, input logic [WAY_NUM-1:0] vl,
                               input logic [WAY_NUM-1:0] lk, output int w, output bit al);
      int lo, hi, n, mid;
      bit up;
      w = 0; al = 1'b0;
      if (range_locked(lk, 0, WAY_NUM)) begin al = 1'b1; return; end
      for (int i = 0; i < WAY_NUM; i++) if (!vl[i] && !lk[i]) begin w = i; return; end
      lo = 0; hi = WAY_NUM; n = 1;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         up  = ptr_up[s][n];
         if (up ? range_locked(lk, mid, hi) : range_locked(lk, lo, mid)) up = !up;
         if (up) begin lo = mid; n = 2 * n + 1; end
         else    begin hi = mid; n = 2 * n; end
      end
      w = lo;
   endtask

   // one clock: predict from pre-edge model, advance model, clock, check, drop pulses
   task automatic tick();
      bit rdy;
      int w;
      bit al;
      rdy   = (rem == 0);
      e_vld = !rst && rdy && lkp_vld;
      if (e_vld) begin
         model_victim(int'(lkp_set), lkp_valid, lkp_lock, w, al);
         e_way = w; e_all = al;
      end
      if (rst) begin e_way = 0; e_all = 1'b0; end
      if (!rst && rdy)
         for (int p = 0; p < UPD_PORTS; p++)
            if (upd_vld[p]) model_touch(int'(upd_set[p]), int'(upd_way[p]));
      if (rst || flush) begin rem = SET_NUM; model_clear(); end
      else if (rem > 0) rem--;
      @(posedge clk); #1;
      chk("ready", 32'(ready), 32'(rem == 0));
      chk("vic_vld", 32'(vic_vld), 32'(e_vld));
      chk("vic_way", 32'(vic_way), 32'(e_way));
      chk("vic_all_lock", 32'(vic_all_lock), 32'(e_all));
      flush = 1'b0; upd_vld = '0; lkp_vld = 1'b0;
   endtask

   task automatic query(input int s, input logic [WAY_NUM-1:0] vl, input logic [WAY_NUM-1:0] lk);
      lkp_vld = 1'b1; lkp_set = SET_WTH'(s); lkp_valid = vl; lkp_lock = lk;
   endtask

   task automatic touch(input int p, input int s, input int w);
      upd_vld[p] = 1'b1; upd_set[p] = SET_WTH'(s); upd_way[p] = WAY_WTH'(w);
   endtask

   int cnt;

   initial begin
      n_tests = 0; n_fail = 0; rem = SET_NUM; e_way = 0; e_vld = 0; e_all = 0;
      model_clear();
      rst = 1'b1; flush = 1'b0; upd_vld = '0; upd_set = '0; upd_way = '0;
      lkp_vld = 1'b0; lkp_set = '0; lkp_valid = '1; lkp_lock = '0;

      // reset state and initial sweep length
      tick(); tick();
      chk("rst_ready", 32'(ready), 32'(0));
      chk("rst_vld", 32'(vic_vld), 32'(0));
      rst = 1'b0;
      cnt = 0;
      while (!ready && cnt < SET_NUM + 8) begin tick(); cnt++; end
      chk("init_sweep_len", 32'(cnt), 32'(SET_NUM));

      // basic PLRU sequence on set 5
      query(5, 8'hFF, 8'h00); tick();
      chk("q5_vld", 32'(vic_vld), 32'(1));
      chk("q5_way0", 32'(vic_way), 32'(0));
      touch(0, 5, 0); tick();
      query(5, 8'hFF, 8'h00); tick();
      chk("q5_after_t0", 32'(vic_way), 32'(4));
      touch(0, 5, 4); tick();
      query(5, 8'hFF, 8'h00); tick();
      chk("q5_after_t4", 32'(vic_way), 32'(2));
      query(5, 8'hEF, 8'h00); tick();
      chk("q5_invalid_pref", 32'(vic_way), 32'(4));
      query(5, 8'hEF, 8'h10); tick();
      chk("q5_locked_invalid", 32'(vic_way), 32'(2));
      tick();
      chk("hold_vld_drop", 32'(vic_vld), 32'(0));
      chk("hold_way", 32'(vic_way), 32'(2));

      // two ports on one set, plus a same-cycle query seeing the old tree
      touch(0, 9, 0); touch(1, 9, 1); query(9, 8'hFF, 8'h00); tick();
      chk("q9_pre_update", 32'(vic_way), 32'(0));
      query(9, 8'hFF, 8'h00); tick();
      chk("q9_port1_wins", 32'(vic_way), 32'(4));
      query(9, 8'hFF, 8'hFF); tick();
      chk("all_lock_flag", 32'(vic_all_lock), 32'(1));
      chk("all_lock_way", 32'(vic_way), 32'(0));
      query(9, 8'hFF, 8'hF0); tick();
      chk("upper_locked", 32'(vic_way), 32'(2));
      chk("upper_locked_flag", 32'(vic_all_lock), 32'(0));

      // flush: sweep, ignored traffic, cleared trees
      touch(0, 1, 0); touch(1, 2, 5); tick();
      touch(0, 3, 7); tick();
      flush = 1'b1; tick();
      chk("flush_ready_low", 32'(ready), 32'(0));
      touch(0, 1, 3); query(1, 8'hFF, 8'h00); tick();
      chk("flush_lkp_ignored", 32'(vic_vld), 32'(0));
      cnt = 1;
      while (!ready && cnt < SET_NUM + 8) begin
         if (cnt % 16 == 0) query(cnt % 8, 8'hFF, 8'h00);
         tick(); cnt++;
      end
      chk("flush_sweep_len", 32'(cnt), 32'(SET_NUM));
      foreach (upd_vld[i]) upd_vld[i] = 1'b0;
      for (int s = 1; s <= 9; s++) begin
         query(s, 8'hFF, 8'h00); tick();
         chk("post_flush_way0", 32'(vic_way), 32'(0));
      end

      // reset in the middle of a sweep restarts it
      flush = 1'b1; tick();
      repeat (50) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      cnt = 0;
      while (!ready && cnt < SET_NUM + 8) begin tick(); cnt++; end
      chk("rst_resweep_len", 32'(cnt), 32'(SET_NUM));

      // flush inside a sweep restarts the counter too
      flush = 1'b1; tick();
      repeat (30) tick();
      flush = 1'b1; tick();
      cnt = 0;
      while (!ready && cnt < SET_NUM + 8) begin tick(); cnt++; end
      chk("flush_restart_len", 32'(cnt), 32'(SET_NUM));

      // random traffic on a few sets to force conflicts
      for (int i = 0; i < 3000; i++) begin
         for (int p = 0; p < UPD_PORTS; p++)
            if ($urandom_range(0, 1) == 1) touch(p, $urandom_range(0, 7), $urandom_range(0, WAY_NUM - 1));
         if ($urandom_range(0, 1) == 1) begin
            lkp_valid = ($urandom_range(0, 3) == 0) ? WAY_NUM'($urandom) : '1;
            case ($urandom_range(0, 3))
               0:       lkp_lock = '0;
               1:       lkp_lock = WAY_NUM'($urandom);
               2:       lkp_lock = WAY_NUM'($urandom) & WAY_NUM'($urandom);
               default: lkp_lock = ($urandom_range(0, 7) == 0) ? '1 : '0;
            endcase
            lkp_vld = 1'b1;
            lkp_set = SET_WTH'($urandom_range(0, 7));
         end
         if ($urandom_range(0, 999) == 0) flush = 1'b1;
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
